// File: rtl/locked_accumulator.sv
// Key-gated ripple-carry accumulator with a serially loaded lock key.
// Only key {WIDTH{2'b10}} makes the datapath behave as a plain adder.
module locked_accumulator #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             key_bit,
    input  logic             key_valid,
    input  logic             key_commit,
    output logic             key_armed,
    output logic             key_err,
    input  logic             in_valid,
    input  logic             in_clear,
    input  logic [WIDTH-1:0] in_data,
    output logic [WIDTH-1:0] acc_out,
    output logic             carry_out,
    output logic             out_valid
);

    localparam int KEYW = 2 * WIDTH;
    localparam int CW   = $clog2(KEYW + 1);
    localparam logic [CW-1:0] FULL = CW'(KEYW);

    typedef enum logic [1:0] {
        EMPTY,
        SHIFT,
        ARMED
    } state_t;

    state_t            state;
    state_t            state_d;
    logic [KEYW-1:0]   key_sr;
    logic [KEYW-1:0]   key_sr_d;
    logic [KEYW-1:0]   key_reg;
    logic [KEYW-1:0]   key_reg_d;
    logic [CW-1:0]     count;
    logic [CW-1:0]     count_d;
    logic              err_set;

    logic [WIDTH-1:0]  op_a;
    logic [WIDTH-1:0]  sum;
    logic              cy;
    logic              msb_cout;

    always_comb begin
        state_d   = state;
        key_sr_d  = key_sr;
        key_reg_d = key_reg;
        count_d   = count;
        err_set   = 1'b0;
        unique case (state)
            EMPTY: begin
                if (key_commit) begin
                    err_set = 1'b1;
                end else if (key_valid) begin
                    key_sr_d = {key_sr[KEYW-2:0], key_bit};
                    count_d  = CW'(1);
                    state_d  = SHIFT;
                end
            end
            SHIFT: begin
                // Commit wins over a same-cycle shift; that bit is dropped.
                if (key_commit) begin
                    if (count == FULL) begin
                        key_reg_d = key_sr;
                        count_d   = '0;
                        state_d   = ARMED;
                    end else begin
                        err_set = 1'b1;
                    end
                end else if (key_valid) begin
                    key_sr_d = {key_sr[KEYW-2:0], key_bit};
                    if (count != FULL) begin
                        count_d = count + 1'b1;
                    end
                end
            end
            ARMED: begin
            end
            default: state_d = EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= EMPTY;
            key_sr  <= '0;
            key_reg <= '0;
            count   <= '0;
            key_err <= 1'b0;
        end else begin
            state   <= state_d;
            key_sr  <= key_sr_d;
            key_reg <= key_reg_d;
            count   <= count_d;
            key_err <= key_err | err_set;
        end
    end

    assign key_armed = (state == ARMED);

    // Each slice: XNOR key gate on the sum term, XOR key gate on a&c.
    always_comb begin
        op_a = in_clear ? '0 : acc_out;
        sum  = '0;
        cy   = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
            sum[i] = cy ^ ~(op_a[i] ^ in_data[i] ^ key_reg[2*i+1]);
            cy     = ((op_a[i] & cy) ^ key_reg[2*i])
                   | (cy & in_data[i])
                   | (in_data[i] & op_a[i]);
        end
        msb_cout = cy;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_out   <= '0;
            carry_out <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid | in_clear;
            if (in_valid) begin
                acc_out   <= sum;
                carry_out <= msb_cout;
            end else if (in_clear) begin
                acc_out   <= '0;
                carry_out <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_locked_accumulator.sv
// Bench for locked_accumulator: vector table plus key-loading sequences,
// accumulator results checked through an expected-value queue.
module tb_locked_accumulator;

    logic       clk;
    logic       rst_n;
    logic       key_bit;
    logic       key_valid;
    logic       key_commit;
    logic       key_armed;
    logic       key_err;
    logic       in_valid;
    logic       in_clear;
    logic [7:0] in_data;
    logic [7:0] acc_out;
    logic       carry_out;
    logic       out_valid;

    int checks = 0;
    int errors = 0;

    logic [8:0] sb[$];

    localparam logic [15:0] GOOD_KEY = 16'hAAAA;

    typedef struct {
        logic       v;
        logic       c;
        logic [7:0] d;
        logic [7:0] acc;
        logic       co;
    } vec_t;

    vec_t tbl[14];

    locked_accumulator #(.WIDTH(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .key_bit    (key_bit),
        .key_valid  (key_valid),
        .key_commit (key_commit),
        .key_armed  (key_armed),
        .key_err    (key_err),
        .in_valid   (in_valid),
        .in_clear   (in_clear),
        .in_data    (in_data),
        .acc_out    (acc_out),
        .carry_out  (carry_out),
        .out_valid  (out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: run time exceeded");
        $fatal(1, "timeout");
    end

    // Each queued item is due at the negedge following its capture edge.
    always @(negedge clk) begin
        logic [8:0] exp;
        if (rst_n) begin
            checks++;
            if (sb.size() > 0) begin
                exp = sb.pop_front();
                if (out_valid !== 1'b1 || {carry_out, acc_out} !== exp) begin
                    errors++;
                    $display("FAIL acc: out_valid=%0b carry=%0b acc=%h required out_valid=1 carry=%0b acc=%h",
                             out_valid, carry_out, acc_out, exp[8], exp[7:0]);
                end
            end else if (out_valid !== 1'b0) begin
                errors++;
                $display("FAIL out_valid_idle: got %0b required 0", out_valid);
            end
        end
    end

    task automatic chk(input string name, input logic [8:0] act, input logic [8:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    task automatic step(input logic kv, input logic kb, input logic kc,
                        input logic v, input logic c, input logic [7:0] d,
                        input logic [8:0] exp);
        key_valid  = kv;
        key_bit    = kb;
        key_commit = kc;
        in_valid   = v;
        in_clear   = c;
        in_data    = d;
        @(posedge clk);
        if (v || c) sb.push_back(exp);
        #1;
        key_valid  = 1'b0;
        key_commit = 1'b0;
        in_valid   = 1'b0;
        in_clear   = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 9'h000);
    endtask

    task automatic shift_key(input logic [15:0] k, input int hi, input int lo);
        for (int i = hi; i >= lo; i--) begin
            step(1'b1, k[i], 1'b0, 1'b0, 1'b0, 8'h00, 9'h000);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        sb.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        tbl[0]  = '{1'b1, 1'b1, 8'h01, 8'h01, 1'b0};
        tbl[1]  = '{1'b1, 1'b0, 8'hFF, 8'h00, 1'b1};
        tbl[2]  = '{1'b0, 1'b1, 8'h00, 8'h00, 1'b0};
        tbl[3]  = '{1'b1, 1'b0, 8'h40, 8'h40, 1'b0};
        tbl[4]  = '{1'b1, 1'b0, 8'h40, 8'h80, 1'b0};
        tbl[5]  = '{1'b1, 1'b0, 8'h40, 8'hC0, 1'b0};
        tbl[6]  = '{1'b1, 1'b0, 8'h40, 8'h00, 1'b1};
        tbl[7]  = '{1'b1, 1'b0, 8'h55, 8'h55, 1'b0};
        tbl[8]  = '{1'b1, 1'b0, 8'hAB, 8'h00, 1'b1};
        tbl[9]  = '{1'b1, 1'b1, 8'h7F, 8'h7F, 1'b0};
        tbl[10] = '{1'b1, 1'b0, 8'h81, 8'h00, 1'b1};
        tbl[11] = '{1'b1, 1'b0, 8'h12, 8'h12, 1'b0};
        tbl[12] = '{1'b1, 1'b0, 8'hF0, 8'h02, 1'b1};
        tbl[13] = '{1'b0, 1'b1, 8'h00, 8'h00, 1'b0};

        key_bit    = 1'b0;
        key_valid  = 1'b0;
        key_commit = 1'b0;
        in_valid   = 1'b0;
        in_clear   = 1'b0;
        in_data    = 8'h00;
        rst_n      = 1'b0;

        do_reset();
        chk("rst_acc", {carry_out, acc_out}, 9'h000);
        chk("rst_out_valid", {8'h00, out_valid}, 9'h000);
        chk("rst_armed", {8'h00, key_armed}, 9'h000);
        chk("rst_err", {8'h00, key_err}, 9'h000);

        // Zero key: corrupted results.
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h01, {1'b0, 8'hFE});
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h03, {1'b1, 8'hFE});
        idle(2);
        chk("nokey_armed", {8'h00, key_armed}, 9'h000);
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 9'h000);
        chk("empty_commit_err", {8'h00, key_err}, 9'h001);
        chk("empty_commit_armed", {8'h00, key_armed}, 9'h000);

        // Partial key, bad commit, then complete it.
        do_reset();
        shift_key(GOOD_KEY, 15, 6);
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 9'h000);
        chk("short_commit_err", {8'h00, key_err}, 9'h001);
        chk("short_commit_armed", {8'h00, key_armed}, 9'h000);
        shift_key(GOOD_KEY, 5, 0);
        chk("pre_commit_armed", {8'h00, key_armed}, 9'h000);
        step(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 8'h01, {1'b0, 8'hFE});
        chk("commit_armed", {8'h00, key_armed}, 9'h001);
        chk("commit_err_sticky", {8'h00, key_err}, 9'h001);

        for (int i = 0; i < 14; i++) begin
            step(1'b0, 1'b0, 1'b0, tbl[i].v, tbl[i].c, tbl[i].d,
                 {tbl[i].co, tbl[i].acc});
        end
        idle(2);

        // Asynchronous reset while armed with acc = 55.
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h55, {1'b0, 8'h55});
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_acc", {carry_out, acc_out}, 9'h000);
        chk("async_rst_out_valid", {8'h00, out_valid}, 9'h000);
        chk("async_rst_armed", {8'h00, key_armed}, 9'h000);
        chk("async_rst_err", {8'h00, key_err}, 9'h000);
        sb.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h01, {1'b0, 8'hFE});
        idle(2);

        // Commit and shift together: the bit must be dropped.
        shift_key(GOOD_KEY, 15, 0);
        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 9'h000);
        chk("dual_commit_armed", {8'h00, key_armed}, 9'h001);
        chk("dual_commit_err", {8'h00, key_err}, 9'h000);
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 9'h000);
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 9'h000);
        step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 9'h000);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h01, {1'b0, 8'h01});
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'hFF, {1'b1, 8'h00});
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h3C, {1'b0, 8'h3C});
        idle(3);
        chk("armed_hold", {8'h00, key_armed}, 9'h001);
        chk("armed_err_clear", {8'h00, key_err}, 9'h000);
        chk("queue_drained", 9'(sb.size()), 9'h000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
